mm_stream_engine: RTL and testbench

- Parametrised matrix-matrix multiplier: C (ROWS x N) = A (ROWS x N) x B (N x N).
- ROWS is set at run time.
- B is preloaded into an internal register bank from an external synchronous memory.
- A rows are then streamed from external memory through a pipelined multiply/adder-tree datapath, and C rows are written to an external result RAM.
- Has a start/busy/done handshake and sits between the lab ROM/RAM banks and the top-level controller.

---
 rtl/mm_stream_engine.sv | 251 +++++++++++++++++++++++++
 tb/tb_mm_stream_engine.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_stream_engine.sv
// Streaming matrix-matrix multiplier C = A x B with B held in a register bank.
// Define MM_SIGNED_EN to treat A/B elements as two's-complement.
module mm_stream_engine #(
    parameter int N          = 4,
    parameter int DW         = 8,
    parameter int BRAM_DEPTH = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [$clog2(BRAM_DEPTH):0]               rows,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      b_rd_en,
    output logic [$clog2(N)-1:0]                      b_rd_addr,
    input  logic [N*DW-1:0]                           b_rd_data,
    output logic                                      a_rd_en,
    output logic [$clog2(BRAM_DEPTH)-1:0]             a_rd_addr,
    input  logic [N*DW-1:0]                           a_rd_data,
    output logic                                      c_wr_en,
    output logic [$clog2(BRAM_DEPTH)-1:0]             c_wr_addr,
    output logic [N*(2*DW+$clog2(N))-1:0]             c_wr_data
);

    localparam int AW = $clog2(BRAM_DEPTH);
    localparam int NB = $clog2(N);
    localparam int PW = 2 * DW;
    localparam int RW = 2 * DW + NB;
    localparam int CW = (AW + 1 > NB) ? AW + 1 : NB;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_B,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic logic [AW:0] clamp_rows(input logic [AW:0] x);
        return (x > (AW+1)'(BRAM_DEPTH)) ? (AW+1)'(BRAM_DEPTH) : x;
    endfunction

    function automatic logic [PW-1:0] mul_el(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MM_SIGNED_EN
        logic signed [PW-1:0] sa;
        logic signed [PW-1:0] sb;
        logic signed [PW-1:0] p;
        sa = PW'($signed(a));
        sb = PW'($signed(b));
        p  = sa * sb;
        return p;
`else
        return PW'(a) * PW'(b);
`endif
    endfunction

    function automatic logic [RW-1:0] ext_el(input logic [PW-1:0] p);
`ifdef MM_SIGNED_EN
        return {{(RW-PW){p[PW-1]}}, p};
`else
        return {{(RW-PW){1'b0}}, p};
`endif
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;
    logic [AW:0]     r_rows_q;
    logic [AW:0]     w_rows_nxt;
    logic [AW:0]     w_rows_clamped;
    logic            w_busy;
    logic            w_done;
    logic            w_b_rd_en;
    logic            w_a_rd_en;

    logic            r_bcap_vld;
    logic [NB-1:0]   r_bcap_addr;
    logic [N*DW-1:0] r_bbank [N];

    logic            r_vld_p0;
    logic [AW-1:0]   r_addr_p0;
    logic            r_vld_p1;
    logic [AW-1:0]   r_addr_p1;
    logic [PW-1:0]   r_prod_p1 [N][N];
    logic            r_vld_p2;
    logic [AW-1:0]   r_addr_p2;
    logic [RW-1:0]   r_sum_p2 [N];
    logic [RW-1:0]   w_sum [N];

    assign w_cnt_inc      = r_cnt + CW'(1);
    assign w_rows_clamped = clamp_rows(rows);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rows_q <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rows_q <= w_rows_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rows_nxt  = r_rows_q;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_b_rd_en   = 1'b0;
        w_a_rd_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_rows_nxt  = w_rows_clamped;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (w_rows_clamped == '0) ? S_DONE : S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                w_busy    = 1'b1;
                w_b_rd_en = 1'b1;
                if (r_cnt == CW'(N - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_RUN: begin
                w_busy    = 1'b1;
                w_a_rd_en = 1'b1;
                if (w_cnt_inc == CW'(r_rows_q)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                // The final write is in flight once the first two stages are empty.
                if (!r_vld_p0 && !r_vld_p1) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy      = w_busy;
    assign done      = w_done;
    assign b_rd_en   = w_b_rd_en;
    assign a_rd_en   = w_a_rd_en;
    assign b_rd_addr = w_b_rd_en ? r_cnt[NB-1:0] : '0;
    assign a_rd_addr = w_a_rd_en ? r_cnt[AW-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcap_vld  <= 1'b0;
            r_bcap_addr <= '0;
            for (int k = 0; k < N; k++) begin
                r_bbank[k] <= '0;
            end
        end else begin
            r_bcap_vld  <= w_b_rd_en;
            r_bcap_addr <= b_rd_addr;
            if (r_bcap_vld) begin
                r_bbank[r_bcap_addr] <= b_rd_data;
            end
        end
    end

    // Stage p0: A row arrives from memory; track its address and valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p0  <= 1'b0;
            r_addr_p0 <= '0;
        end else begin
            r_vld_p0  <= w_a_rd_en;
            r_addr_p0 <= a_rd_addr;
        end
    end

    // Stage p1: all N*N lane products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_addr_p1 <= '0;
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < N; j++) begin
                    r_prod_p1[k][j] <= '0;
                end
            end
        end else begin
            r_vld_p1  <= r_vld_p0;
            r_addr_p1 <= r_addr_p0;
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < N; j++) begin
                    r_prod_p1[k][j] <= mul_el(a_rd_data[k*DW +: DW], r_bbank[k][j*DW +: DW]);
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            w_sum[j] = '0;
            for (int k = 0; k < N; k++) begin
                w_sum[j] = w_sum[j] + ext_el(r_prod_p1[k][j]);
            end
        end
    end

    // Stage p2: column sums, presented directly as the C write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_addr_p2 <= '0;
            for (int j = 0; j < N; j++) begin
                r_sum_p2[j] <= '0;
            end
        end else begin
            r_vld_p2  <= r_vld_p1;
            r_addr_p2 <= r_addr_p1;
            for (int j = 0; j < N; j++) begin
                r_sum_p2[j] <= w_sum[j];
            end
        end
    end

    assign c_wr_en   = r_vld_p2;
    assign c_wr_addr = r_addr_p2;

    always_comb begin
        c_wr_data = '0;
        for (int j = 0; j < N; j++) begin
            c_wr_data[j*RW +: RW] = r_sum_p2[j];
        end
    end

endmodule

// File: tb/tb_mm_stream_engine.sv
// Directed testbench for mm_stream_engine with synchronous A/B memory models.
// Build with MM_SIGNED_EN defined to exercise the two's-complement variant.
module tb_mm_stream_engine;

    localparam int N = 4;
`ifdef MM_SIGNED_EN
    localparam int DW = 4;
`else
    localparam int DW = 8;
`endif
    localparam int BRAM_DEPTH = 32;
    localparam int AW = 5;
    localparam int NB = 2;
    localparam int RW = 2 * DW + NB;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [AW:0]         rows;
    logic                busy;
    logic                done;
    logic                b_rd_en;
    logic [NB-1:0]       b_rd_addr;
    logic [N*DW-1:0]     b_rd_data = '0;
    logic                a_rd_en;
    logic [AW-1:0]       a_rd_addr;
    logic [N*DW-1:0]     a_rd_data = '0;
    logic                c_wr_en;
    logic [AW-1:0]       c_wr_addr;
    logic [N*RW-1:0]     c_wr_data;

    logic [N*DW-1:0]     bmem [N];
    logic [N*DW-1:0]     amem [BRAM_DEPTH];
    logic [N*RW-1:0]     cmem [BRAM_DEPTH];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    int wr_cnt = 0, a_cnt = 0, b_cnt = 0, done_cnt = 0, busy_cnt = 0, order_err = 0;
    int first_wr = 0, last_wr = 0, nxt_addr = 0;
    bit fresh = 1'b1;

    int s_wr, s_a, s_b, s_done, s_busy, s_ord;
    int j_wr, j_a, j_b, j_done, j_busy, j_ord, j_lat;
    int st;

    mm_stream_engine #(.N(N), .DW(DW), .BRAM_DEPTH(BRAM_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rows      (rows),
        .busy      (busy),
        .done      (done),
        .b_rd_en   (b_rd_en),
        .b_rd_addr (b_rd_addr),
        .b_rd_data (b_rd_data),
        .a_rd_en   (a_rd_en),
        .a_rd_addr (a_rd_addr),
        .a_rd_data (a_rd_data),
        .c_wr_en   (c_wr_en),
        .c_wr_addr (c_wr_addr),
        .c_wr_data (c_wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (b_rd_en) b_rd_data <= bmem[b_rd_addr];
        if (a_rd_en) a_rd_data <= amem[a_rd_addr];
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                nxt_addr = 0;
                fresh    = 1'b1;
            end
            if (c_wr_en) begin
                if (fresh) first_wr = cyc;
                fresh   = 1'b0;
                last_wr = cyc;
                if (int'(c_wr_addr) != nxt_addr) order_err++;
                nxt_addr = int'(c_wr_addr) + 1;
                cmem[c_wr_addr] = c_wr_data;
                wr_cnt++;
            end
            if (a_rd_en) a_cnt++;
            if (b_rd_en) b_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                nxt_addr = 0;
                fresh    = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [N*DW-1:0] pa(input int a0, input int a1, input int a2, input int a3);
        return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    function automatic logic [N*RW-1:0] pc(input int c0, input int c1, input int c2, input int c3);
        return {RW'(c3), RW'(c2), RW'(c1), RW'(c0)};
    endfunction

    // Unsigned reference: C[r][j] = sum_k A[r][k] * B[k][j].
    function automatic logic [N*RW-1:0] ref_row(input int r);
        logic [N*RW-1:0] res;
        int s;
        res = '0;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++) begin
                s += int'(amem[r][k*DW +: DW]) * int'(bmem[k][j*DW +: DW]);
            end
            res[j*RW +: RW] = RW'(s);
        end
        return res;
    endfunction

    task automatic snap();
        @(posedge clk);
        #1;
        s_wr = wr_cnt; s_a = a_cnt; s_b = b_cnt; s_done = done_cnt;
        s_busy = busy_cnt; s_ord = order_err;
    endtask

    task automatic deltas();
        j_wr = wr_cnt - s_wr; j_a = a_cnt - s_a; j_b = b_cnt - s_b;
        j_done = done_cnt - s_done; j_busy = busy_cnt - s_busy; j_ord = order_err - s_ord;
    endtask

    task automatic kick(input int r);
        @(negedge clk);
        rows  = (AW+1)'(r);
        start = 1'b1;
        st    = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk({tag, "_timeout"}, 0, 1);
        j_lat = cyc - st;
    endtask

    task automatic run_job(input int r, input string tag);
        snap();
        kick(r);
        wait_done(tag);
        @(negedge clk);
        #1;
        deltas();
    endtask

    initial begin
        int bad;
        logic [N*RW-1:0] e0, e1;
        rst   = 1'b1;
        start = 1'b0;
        rows  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", {a_rd_en, b_rd_en}, 0);
        chk("rst_wr_en", c_wr_en, 0);
        chk("rst_addr", {a_rd_addr, b_rd_addr, c_wr_addr}, 0);
        chk("rst_wr_data", c_wr_data, 0);
        rst = 1'b0;

`ifdef MM_SIGNED_EN
        for (int k = 0; k < N; k++) bmem[k] = '0;
        for (int k = 0; k < N; k++) bmem[k][k*DW +: DW] = DW'(-1);
        amem[0] = pa(-1, 2, -8, 7);
        run_job(1, "sgn");
        chk("sgn_lat", j_lat, 9);
        chk("sgn_wr", j_wr, 1);
        chk("sgn_row", cmem[0], {10'h3F9, 10'h008, 10'h3FE, 10'h001});
        chk("sgn_busy", j_busy, 8);
`else
        // Identity B
        bmem[0] = pa(1, 0, 0, 0); bmem[1] = pa(0, 1, 0, 0);
        bmem[2] = pa(0, 0, 1, 0); bmem[3] = pa(0, 0, 0, 1);
        amem[0] = pa(1, 2, 3, 4); amem[1] = pa(5, 6, 7, 8);
        run_job(2, "id");
        chk("id_lat", j_lat, 10);
        chk("id_wr", j_wr, 2);
        chk("id_row0", cmem[0], pc(1, 2, 3, 4));
        chk("id_row1", cmem[1], pc(5, 6, 7, 8));
        chk("id_brd", j_b, 4);
        chk("id_ard", j_a, 2);

        // Maximum operands, full depth
        for (int k = 0; k < N; k++) bmem[k] = '1;
        for (int r = 0; r < BRAM_DEPTH; r++) amem[r] = '1;
        run_job(32, "max");
        bad = 0;
        for (int r = 0; r < BRAM_DEPTH; r++) if (cmem[r] !== pc(260100, 260100, 260100, 260100)) bad++;
        chk("max_data", bad, 0);
        chk("max_wr", j_wr, 32);
        chk("max_order", j_ord, 0);
        chk("max_nobubble", last_wr - first_wr, 31);
        chk("max_lat", j_lat, 40);

        // rows = 0
        run_job(0, "zero");
        chk("zero_lat", j_lat, 1);
        chk("zero_rd", j_a + j_b, 0);
        chk("zero_wr", j_wr, 0);
        chk("zero_busy", j_busy, 0);

        // rows above depth is clamped
        bmem[0] = pa(1, 2, 3, 4);     bmem[1] = pa(5, 6, 7, 8);
        bmem[2] = pa(9, 10, 11, 12);  bmem[3] = pa(13, 14, 15, 16);
        for (int r = 0; r < BRAM_DEPTH; r++) amem[r] = pa(r + 1, 2 * r + 3, (7 * r) % 256, 255 - r);
        run_job(40, "clamp");
        chk("clamp_wr", j_wr, 32);
        chk("clamp_ard", j_a, 32);
        chk("clamp_lat", j_lat, 40);
        chk("clamp_order", j_ord, 0);
        chk("clamp_row31", cmem[31], ref_row(31));
        chk("clamp_row5", cmem[5], ref_row(5));

        // start during RUN and during DONE must be ignored
        snap();
        kick(3);
        repeat (5) @(negedge clk);
        rows  = 6'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("hs");
        chk("hs_lat", j_lat, 11);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        deltas();
        chk("hs_done", j_done, 1);
        chk("hs_wr", j_wr, 3);
        chk("hs_brd", j_b, 4);

        // Back-to-back start the cycle after DONE, with a new B
        for (int r = 0; r < 2; r++) amem[r] = pa(11 * r + 3, 250 - r, 17, 99 + r);
        snap();
        kick(2);
        wait_done("b2b1");
        chk("b2b1_row0", cmem[0], ref_row(0));
        chk("b2b1_row1", cmem[1], ref_row(1));
        bmem[0] = pa(200, 0, 17, 3);  bmem[1] = pa(1, 255, 2, 254);
        bmem[2] = pa(8, 16, 32, 64);  bmem[3] = pa(7, 0, 0, 128);
        e0 = ref_row(0);
        e1 = ref_row(1);
        @(negedge clk);
        rows  = 6'd2;
        start = 1'b1;
        st    = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b2");
        chk("b2b2_lat", j_lat, 10);
        @(negedge clk);
        #1;
        deltas();
        chk("b2b2_row0", cmem[0], e0);
        chk("b2b2_row1", cmem[1], e1);
        chk("b2b_done", j_done, 2);
        chk("b2b_brd", j_b, 8);

        // Reset mid-RUN
        snap();
        kick(10);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_en", {a_rd_en, b_rd_en, c_wr_en, done}, 0);
        chk("mrst_data", c_wr_data, 0);
        chk("mrst_addr", {a_rd_addr, c_wr_addr}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        deltas();
        chk("mrst_ard", j_a, 3);
        chk("mrst_nowr", j_wr, 0);
        chk("mrst_nodone", j_done, 0);
        amem[0] = pa(9, 8, 7, 6);
        run_job(1, "post");
        chk("post_lat", j_lat, 9);
        chk("post_wr", j_wr, 1);
        chk("post_row", cmem[0], ref_row(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
